// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_pkg: shared widths and FIFO entry type for the writeback arbiter
package regfile_wb_pkg;
    localparam int ADDR_W = 5;
    localparam int N_REG = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int WB_DATA_W = 16;
    typedef struct packed {
        logic                 live;
        logic [ADDR_W-1:0]    addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: producer, decode-read and register-file write signals of the arbiter
interface regfile_wb_arbiter_if
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              pipe_wb_valid;
    logic [ADDR_W-1:0] pipe_wb_addr;
    logic [DATA_W-1:0] pipe_wb_data;
    logic              mul_valid;
    logic              mul_ready;
    logic [ADDR_W-1:0] mul_addr;
    logic [DATA_W-1:0] mul_data;
    logic [ADDR_W-1:0] raddr_1;
    logic [ADDR_W-1:0] raddr_2;
    logic              pend_hit_1;
    logic              pend_hit_2;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [CW-1:0]     fifo_count;
    logic [15:0]       stall_cnt;
    logic [15:0]       kill_cnt;
    modport slave (
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data, mul_valid, mul_addr, mul_data,
               raddr_1, raddr_2,
        output mul_ready, pend_hit_1, pend_hit_2, reg_write, waddr, wdata, fifo_count,
               stall_cnt, kill_cnt
    );
    modport master (
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data, mul_valid, mul_addr, mul_data,
               raddr_1, raddr_2,
        input  mul_ready, pend_hit_1, pend_hit_2, reg_write, waddr, wdata, fifo_count,
               stall_cnt, kill_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_kill_fifo.sv
// wb_kill_fifo: multiplier result FIFO with kill-by-address and pending-hit compare (WB_STATS_EN adds kill_n)
module wb_kill_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [WB_DATA_W-1:0]          push_data,
    input  logic                          pop,
    input  logic                          kill_en,
    input  logic [ADDR_W-1:0]             kill_addr,
    input  logic [ADDR_W-1:0]             raddr_1,
    input  logic [ADDR_W-1:0]             raddr_2,
    output wb_entry_t                     head,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
`ifdef WB_STATS_EN
    output logic [$clog2(DEPTH):0]        kill_n,
`endif
    output logic                          hit_1,
    output logic                          hit_2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    assign head = mem_q[rd_q];
    assign empty = count_q == '0;
    assign full = count_q == CW'(DEPTH);
    assign count = count_q;
    // Kill matching entries, retire the popped slot (live cleared so stale slots never hit), then push
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill_en && mem_q[i].live && mem_q[i].addr == kill_addr) mem_d[i].live = 1'b0;
        if (pop) mem_d[rd_q].live = 1'b0;
        if (push) mem_d[wr_q] = '{live: 1'b1, addr: push_addr, data: push_data};
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end
    // Pending-write hits against live entries; register 0 never hits
    always_comb begin
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_1 = hit_1 || (mem_q[i].live && mem_q[i].addr == raddr_1);
            hit_2 = hit_2 || (mem_q[i].live && mem_q[i].addr == raddr_2);
        end
        hit_1 = hit_1 && raddr_1 != ZERO_REG;
        hit_2 = hit_2 && raddr_2 != ZERO_REG;
    end
`ifdef WB_STATS_EN
    // Number of entries killed this cycle
    always_comb begin
        kill_n = '0;
        for (int i = 0; i < DEPTH; i++)
            kill_n = kill_n + CW'(kill_en && mem_q[i].live && mem_q[i].addr == kill_addr);
    end
`endif
    // Storage, pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates pipeline and multiplier results onto the register-file write port (WB_STATS_EN adds stall/kill counters)
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic pipe_go, accept, same_addr, pop, bypass, push, empty, full;
    wb_entry_t head;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    assign pipe_go = bus.pipe_wb_valid && bus.pipe_wb_addr != ZERO_REG;
    assign bus.mul_ready = !rst && !full;
    assign accept = bus.mul_valid && bus.mul_ready;
    assign same_addr = pipe_go && bus.mul_addr == bus.pipe_wb_addr;
    assign pop = !pipe_go && !empty;
    assign bypass = !pipe_go && empty && accept;
    assign push = accept && !bypass && bus.mul_addr != ZERO_REG && !same_addr;
`ifdef WB_STATS_EN
    logic [CW-1:0] kill_n;
`endif
    wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (bus.mul_addr),
        .push_data (bus.mul_data),
        .pop       (pop),
        .kill_en   (pipe_go),
        .kill_addr (bus.pipe_wb_addr),
        .raddr_1   (bus.raddr_1),
        .raddr_2   (bus.raddr_2),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (bus.fifo_count),
`ifdef WB_STATS_EN
        .kill_n    (kill_n),
`endif
        .hit_1     (bus.pend_hit_1),
        .hit_2     (bus.pend_hit_2)
    );
    // Priority select: pipeline, then FIFO head (killed head pops silently), then multiplier bypass
    always_comb begin
        reg_write_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_go) begin
            reg_write_d = 1'b1;
            waddr_d = bus.pipe_wb_addr;
            wdata_d = bus.pipe_wb_data;
        end else if (pop && head.live && head.addr != ZERO_REG) begin
            reg_write_d = 1'b1;
            waddr_d = head.addr;
            wdata_d = head.data;
        end else if (bypass && bus.mul_addr != ZERO_REG) begin
            reg_write_d = 1'b1;
            waddr_d = bus.mul_addr;
            wdata_d = bus.mul_data;
        end
    end
    // Registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
    assign bus.reg_write = reg_write_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
`ifdef WB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, kill_cnt_q, kill_cnt_d;
    logic [16:0] kill_sum;
    // Saturating counters: backpressure cycles and discarded writes (kills plus same-cycle drops)
    always_comb begin
        kill_sum = 17'(kill_cnt_q) + 17'(kill_n) + 17'(accept && same_addr);
        stall_cnt_d = (bus.mul_valid && !bus.mul_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        kill_cnt_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.kill_cnt = kill_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.kill_cnt = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plan plus random traffic checked against a queue-based model
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_wb_arbiter_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();
    regfile_wb_arbiter #(.DATA_W(16), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    typedef struct {
        bit        live;
        bit [4:0]  a;
        bit [15:0] d;
    } ent_t;
    ent_t q[$];
    bit        exp_we = 1'b0;
    bit [4:0]  exp_wa = '0;
    bit [15:0] exp_wd = '0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(bit r, bit pv, bit [4:0] pa, bit [15:0] pd, bit mv, bit [4:0] ma, bit [15:0] md,
                         bit [4:0] r1, bit [4:0] r2);
        rst = r;
        bus.pipe_wb_valid = pv;
        bus.pipe_wb_addr = pa;
        bus.pipe_wb_data = pd;
        bus.mul_valid = mv;
        bus.mul_addr = ma;
        bus.mul_data = md;
        bus.raddr_1 = r1;
        bus.raddr_2 = r2;
    endtask
    function automatic bit model_hit(bit [4:0] ra);
        if (ra == 0) return 1'b0;
        foreach (q[i]) if (q[i].live && q[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction
    // One cycle: check combinational outputs, advance the model, check the registered write port
    task automatic step();
        bit ready, acc;
        bit [4:0] pa, ma;
        ent_t h;
        #1;
        ready = !rst && q.size() < DEPTH;
        chk("mul_ready", 32'(bus.mul_ready), 32'(ready));
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("pend_hit_1", 32'(bus.pend_hit_1), 32'(model_hit(bus.raddr_1)));
        chk("pend_hit_2", 32'(bus.pend_hit_2), 32'(model_hit(bus.raddr_2)));
        pa = bus.pipe_wb_addr;
        ma = bus.mul_addr;
        if (rst) begin
            q.delete();
            exp_we = 1'b0;
            exp_wa = '0;
            exp_wd = '0;
        end else begin
            acc = bus.mul_valid && ready;
            exp_we = 1'b0;
            if (bus.pipe_wb_valid && pa != 0) begin
                exp_we = 1'b1;
                exp_wa = pa;
                exp_wd = bus.pipe_wb_data;
                foreach (q[i]) if (q[i].a == pa) q[i].live = 1'b0;
                if (acc && ma != 0 && ma != pa) q.push_back('{1'b1, ma, bus.mul_data});
            end else if (q.size() > 0) begin
                h = q.pop_front();
                if (h.live) begin
                    exp_we = 1'b1;
                    exp_wa = h.a;
                    exp_wd = h.d;
                end
                if (acc && ma != 0) q.push_back('{1'b1, ma, bus.mul_data});
            end else if (acc && ma != 0) begin
                exp_we = 1'b1;
                exp_wa = ma;
                exp_wd = bus.mul_data;
            end
        end
        @(posedge clk);
        #1;
        chk("reg_write", 32'(bus.reg_write), 32'(exp_we));
        chk("waddr", 32'(bus.waddr), 32'(exp_wa));
        chk("wdata", 32'(bus.wdata), 32'(exp_wd));
    endtask
    initial begin
        drive(1, 0, 0, 0, 1, 5, 16'h1111, 0, 0);
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_reg_write", 32'(bus.reg_write), 0);
        chk("rst_waddr", 32'(bus.waddr), 0);
        chk("rst_wdata", 32'(bus.wdata), 0);
        chk("rst_count", 32'(bus.fifo_count), 0);
        chk("rst_mul_ready", 32'(bus.mul_ready), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_ready", 32'(bus.mul_ready), 1);
        chk("post_rst_no_write", 32'(bus.reg_write), 0);
        drive(0, 0, 0, 0, 1, 5, 16'h1234, 0, 0);
        step();
        chk("bypass_we", 32'(bus.reg_write), 1);
        chk("bypass_addr", 32'(bus.waddr), 5);
        chk("bypass_data", 32'(bus.wdata), 32'h1234);
        chk("bypass_count", 32'(bus.fifo_count), 0);
        drive(0, 1, 3, 16'hAAAA, 1, 7, 16'hBBBB, 7, 0);
        step();
        chk("coll1_addr", 32'(bus.waddr), 3);
        chk("coll1_data", 32'(bus.wdata), 32'hAAAA);
        chk("coll1_hit", 32'(bus.pend_hit_1), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
        step();
        chk("coll2_addr", 32'(bus.waddr), 7);
        chk("coll2_data", 32'(bus.wdata), 32'hBBBB);
        chk("coll2_hit", 32'(bus.pend_hit_1), 0);
        drive(0, 1, 1, 16'h0101, 1, 8, 16'h0808, 0, 0);
        step();
        drive(0, 1, 2, 16'h0202, 1, 9, 16'h0909, 0, 0);
        step();
        chk("full_count", 32'(bus.fifo_count), 2);
        chk("full_ready", 32'(bus.mul_ready), 0);
        drive(0, 1, 3, 16'h0303, 1, 10, 16'h0a0a, 0, 0);
        step();
        drive(0, 1, 4, 16'h0404, 1, 10, 16'h0a0a, 0, 0);
        step();
        chk("full_pipe4", 32'(bus.waddr), 4);
        drive(0, 0, 0, 0, 1, 10, 16'h0a0a, 0, 0);
        step();
        chk("full_r8", 32'(bus.waddr), 8);
        chk("full_r8_data", 32'(bus.wdata), 32'h0808);
        drive(0, 0, 0, 0, 1, 10, 16'h0a0a, 0, 0);
        step();
        chk("full_r9", 32'(bus.waddr), 9);
        chk("full_r10_taken", 32'(bus.fifo_count), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("full_r10", 32'(bus.waddr), 10);
        chk("full_r10_data", 32'(bus.wdata), 32'h0a0a);
        drive(0, 1, 2, 16'h2222, 1, 9, 16'h5555, 0, 9);
        step();
        chk("kill_buffered_hit", 32'(bus.pend_hit_2), 1);
        drive(0, 1, 9, 16'h0001, 0, 0, 0, 0, 9);
        step();
        chk("kill_write_data", 32'(bus.wdata), 32'h0001);
        chk("kill_hit_drop", 32'(bus.pend_hit_2), 0);
        chk("kill_count", 32'(bus.fifo_count), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9);
        step();
        chk("kill_pop_no_write", 32'(bus.reg_write), 0);
        chk("kill_pop_count", 32'(bus.fifo_count), 0);
        drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        step();
        chk("zero_pipe", 32'(bus.reg_write), 0);
        drive(0, 0, 0, 0, 1, 0, 16'h7777, 0, 0);
        #1;
        chk("zero_mul_ready", 32'(bus.mul_ready), 1);
        step();
        chk("zero_mul", 32'(bus.reg_write), 0);
        chk("zero_mul_count", 32'(bus.fifo_count), 0);
        drive(0, 1, 4, 16'h4444, 1, 11, 16'h0b0b, 0, 0);
        step();
        drive(0, 1, 5, 16'h0005, 1, 0, 16'h9999, 0, 0);
        step();
        chk("zero_mul_busy_count", 32'(bus.fifo_count), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("zero_mul_r11", 32'(bus.waddr), 11);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 16'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (n % 500 > 400) bus.pipe_wb_valid = 1'b0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
